irom_fetch: RTL and testbench
=============================

Name: irom_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction ROM.
- Generates word addresses and chip-select for the ROM, absorbs its fixed 1-cycle registered read latency, and buffers returned words in a small FIFO.
- Presents the buffered words to the core decode stage as {PC, instruction} over a valid/ready handshake.
- Handles branch redirects by flushing buffered and in-flight fetches.

Parameters:
- ADDR_W, 24, word-address width; matches the ROM ADDR port.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 24'h000000, first fetch address after reset.

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FETCH_EN  input  1  allows new ROM reads when high.
- JMP_VLD  input  1  redirect strobe, one cycle.
- JMP_ADDR  input  ADDR_W  redirect target word address.
- IROM_ADDR  output  ADDR_W  ROM word address.
- IROM_CS  output  1  ROM read strobe; data returns the next cycle.
- IROM_DOUT  input  32  ROM read data.
- INST_VLD  output  1  FIFO head valid.
- INST_READY  input  1  consumer accepts head.
- INST_DATA  output  32  head instruction.
- INST_PC  output  ADDR_W  head instruction word address.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - pc=RESET_PC, inflight=0, FIFO empty, state=IDLE.
  - Outputs: IROM_CS=0, IROM_ADDR=RESET_PC, INST_VLD=0, INST_DATA=0, INST_PC=0.
- Ready-to-issue condition: `space = (count - pop + inflight) < DEPTH`, where `pop = INST_VLD & INST_READY`.
- State machine:
  - IDLE: no issue. Goes to RUN when FETCH_EN=1.
  - RUN: IROM_CS=1 when space=1 and JMP_VLD=0; IROM_ADDR=pc; pc increments on each issue. Goes to IDLE when FETCH_EN=0; the in-flight read still completes and is captured.
- IROM_CS and IROM_ADDR are combinational from state, pc, and space. IROM_ADDR=pc at all times.
- ROM return:
  - inflight <= IROM_CS each cycle.
  - When inflight=1, the write pushes {pc_of_issue, IROM_DOUT}; the issue address is held in a register.
  - IROM_DOUT is sampled only when inflight=1. The ROM holds its output when CS is low, and that held value is ignored.
- FIFO:
  - Registered head. INST_VLD = (count!=0). INST_DATA/INST_PC show the head entry.
  - Push and pop may occur in the same cycle at any fill level; count is unchanged.
  - Overflow is impossible by the space rule. A push while count==DEPTH is an assertion failure.
- Redirect (JMP_VLD=1, cycle t):
  - In cycle t: pc<=JMP_ADDR, FIFO cleared, inflight cleared (the response arriving at t+1 is discarded), IROM_CS=0. A concurrent pop is ignored.
  - t+1: IROM_CS=1, IROM_ADDR=JMP_ADDR (if RUN).
  - t+3: INST_VLD=1, INST_PC=JMP_ADDR.
  - JMP_VLD in IDLE updates pc and flushes likewise.
  - Back-to-back JMP_VLD: the last one wins.
- Latency after reset release with FETCH_EN=1:
  - First cycle: IDLE->RUN.
  - Next cycle: CS with addr RESET_PC.
  - Two cycles later: INST_VLD.
- Throughput: one instruction per cycle sustained with INST_READY=1 and DEPTH>=2.
- pc wraps modulo 2^ADDR_W (24'hFFFFFF -> 0). The ROM decodes low bits only; that is not this block's concern.
- Reset mid-operation: immediately returns to reset values. In-flight data is lost; no stale push occurs after RST_N rises.

Decomposition:
- Shared package:
  - Constants: IADDR_W=24, INST_W=32, state encoding (IDLE=1'b0, RUN=1'b1).
  - A typedef for the FIFO entry {pc, inst}, usable by the decode stage.
- One sub-module: irom_fetch_fifo (synchronous FIFO, DEPTH x (ADDR_W+32), with flush input, count output, push/pop).
- Address generation, inflight tracking, and the FSM stay in the top.

Test Plan:
- Reset, FETCH_EN=1, INST_READY=1, ROM preloaded with word i = 32'hA0000000+i -> CS at cycles 1..N with ADDR 0,1,2,...; INST_VLD from cycle 3; then INST_PC=k, INST_DATA=A0000000+k every cycle, no bubbles.
- INST_READY=0 with DEPTH=4 -> exactly 4 CS pulses then CS=0; FIFO holds PCs 0..3. Raise READY -> one new CS per pop; no lost or duplicated PCs.
- JMP_VLD at cycle 10 with JMP_ADDR=24'h000100 while 2 entries are buffered and 1 read is in flight -> INST_VLD=0 at cycle 11. Next delivered INST_PC=0x100 at cycle 13; no PC from the old stream appears.
- pc=24'hFFFFFE, free-running -> delivered PCs FFFFFE, FFFFFF, 000000, 000001.
- Drop FETCH_EN with 1 read in flight -> that word is delivered and no further CS. Re-enable -> fetch resumes at the next sequential pc.
- Assert RST_N=0 asynchronously mid-stream -> all outputs at reset values within the same cycle. After release, the first delivered INST_PC=RESET_PC.

Source files
------------

// File: rtl/irom_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage and its consumers.
package irom_fetch_pkg;

  localparam int unsigned IADDR_W = 24;
  localparam int unsigned INST_W  = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [IADDR_W-1:0] pc;
    logic [INST_W-1:0]  inst;
  } fetch_entry_t;

endpackage

// File: rtl/irom_fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is always visible on head_o.
module irom_fetch_fifo #(
  parameter int unsigned  WIDTH = 56,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Flush wins over any concurrent push or pop; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !do_pop && !flush_i && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/irom_fetch.sv
// Instruction fetch: issues ROM reads, absorbs the 1-cycle ROM latency and
// buffers {pc, inst} for decode; a redirect flushes buffered and in-flight words.
module irom_fetch
  import irom_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FETCH_EN,
  input  logic              JMP_VLD,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  output logic [ADDR_W-1:0] IROM_ADDR,
  output logic              IROM_CS,
  input  logic [INST_W-1:0] IROM_DOUT,
  output logic              INST_VLD,
  input  logic              INST_READY,
  output logic [INST_W-1:0] INST_DATA,
  output logic [ADDR_W-1:0] INST_PC
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] issue_pc_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ;
  logic              pop;
  logic              push;
  logic              space;
  logic [ENT_W-1:0]  head;

  assign pop       = INST_VLD && INST_READY;
  assign push      = inflight_q && !JMP_VLD;
  // Reserve a slot for every read still in flight so the FIFO cannot overflow.
  assign occ       = OCC_W'(count) - OCC_W'(pop) + OCC_W'(inflight_q);
  assign space     = occ < OCC_W'(DEPTH);
  assign IROM_ADDR = pc_q;
  assign INST_VLD  = (count != '0);
  assign INST_DATA = head[INST_W-1:0];
  assign INST_PC   = head[ENT_W-1:INST_W];

  // Next state, ROM strobe and next pc.
  always_comb begin
    state_d = state_q;
    IROM_CS = 1'b0;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (FETCH_EN) state_d = ST_RUN;
      end
      ST_RUN: begin
        IROM_CS = space && !JMP_VLD;
        if (!FETCH_EN) state_d = ST_IDLE;
      end
    endcase
    if (JMP_VLD) begin
      pc_d = JMP_ADDR;
    end else if (IROM_CS) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= IROM_CS && !JMP_VLD;
      if (IROM_CS) begin
        issue_pc_q <= pc_q;
      end
    end
  end

  irom_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .flush_i (JMP_VLD),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({issue_pc_q, IROM_DOUT}),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_irom_fetch.sv
// Directed bench for irom_fetch with a registered ROM model and an in-order scoreboard.
module tb_irom_fetch;
  import irom_fetch_pkg::*;

  localparam logic [IADDR_W-1:0] RESET_PC = 24'h000000;

  logic               CLK;
  logic               RST_N;
  logic               FETCH_EN;
  logic               JMP_VLD;
  logic [IADDR_W-1:0] JMP_ADDR;
  logic [IADDR_W-1:0] IROM_ADDR;
  logic               IROM_CS;
  logic [INST_W-1:0]  IROM_DOUT;
  logic               INST_VLD;
  logic               INST_READY;
  logic [INST_W-1:0]  INST_DATA;
  logic [IADDR_W-1:0] INST_PC;

  int total = 0;
  int bad   = 0;

  fetch_entry_t       sb[$];
  logic [IADDR_W-1:0] exp_pc;

  irom_fetch #(
    .ADDR_W   (IADDR_W),
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FETCH_EN   (FETCH_EN),
    .JMP_VLD    (JMP_VLD),
    .JMP_ADDR   (JMP_ADDR),
    .IROM_ADDR  (IROM_ADDR),
    .IROM_CS    (IROM_CS),
    .IROM_DOUT  (IROM_DOUT),
    .INST_VLD   (INST_VLD),
    .INST_READY (INST_READY),
    .INST_DATA  (INST_DATA),
    .INST_PC    (INST_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [INST_W-1:0] rom_word(input logic [IADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // ROM: registered read, output held while CS is low.
  always @(posedge CLK) begin
    if (IROM_CS) IROM_DOUT <= rom_word(IROM_ADDR);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge: check issues against the pc model, pops against the queue.
  task automatic tick();
    fetch_entry_t e;
    @(negedge CLK);
    if (JMP_VLD) begin
      chk("jmp_cs_low", 64'(IROM_CS), 64'd0);
      sb.delete();
      exp_pc = JMP_ADDR;
    end else begin
      if (IROM_CS) begin
        chk("issue_addr", 64'(IROM_ADDR), 64'(exp_pc));
        e.pc   = exp_pc;
        e.inst = rom_word(exp_pc);
        sb.push_back(e);
        exp_pc = exp_pc + 24'd1;
      end
      if (INST_VLD && INST_READY) begin
        e = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        chk("pop_pc", 64'(INST_PC), 64'(e.pc));
        chk("pop_data", 64'(INST_DATA), 64'(e.inst));
      end
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST_N = 1'b0;
    nxt();
    sb.delete();
    exp_pc = RESET_PC;
    RST_N  = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"},   64'(IROM_CS),   64'd0);
    chk({tag, "_addr"}, 64'(IROM_ADDR), 64'(RESET_PC));
    chk({tag, "_vld"},  64'(INST_VLD),  64'd0);
    chk({tag, "_data"}, 64'(INST_DATA), 64'd0);
    chk({tag, "_pc"},   64'(INST_PC),   64'd0);
  endtask

  initial begin
    int ncs;
    int n;
    logic               seen;
    logic [IADDR_W-1:0] first_pc;
    logic [IADDR_W-1:0] got  [4];
    logic [IADDR_W-1:0] want [4];

    RST_N      = 1'b0;
    FETCH_EN   = 1'b0;
    JMP_VLD    = 1'b0;
    JMP_ADDR   = '0;
    INST_READY = 1'b0;
    exp_pc     = RESET_PC;
    #1;
    chk_reset_outputs("rst");

    // Startup latency and sustained streaming.
    FETCH_EN   = 1'b1;
    INST_READY = 1'b1;
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c == 0) chk("lat_c0_cs", 64'(IROM_CS), 64'd0);
      if (c == 1) chk("lat_c1_cs", 64'(IROM_CS), 64'd1);
      if (c == 2) chk("lat_c2_vld", 64'(INST_VLD), 64'd0);
      if (c >= 3) chk("stream_vld", 64'(INST_VLD), 64'd1);
      nxt();
    end

    // Backpressure: exactly DEPTH reads then stall, then resume per pop.
    INST_READY = 1'b0;
    reset_dut();
    ncs = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      ncs += int'(IROM_CS);
      if (c == 9) begin
        chk("bp_cs_count", 64'(ncs), 64'd4);
        chk("bp_vld", 64'(INST_VLD), 64'd1);
        chk("bp_head_pc", 64'(INST_PC), 64'(RESET_PC));
      end
      nxt();
    end
    INST_READY = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      nxt();
    end

    // Redirect with two words buffered and one read in flight.
    FETCH_EN   = 1'b0;
    INST_READY = 1'b0;
    reset_dut();
    for (int c = 0; c < 24; c++) begin
      FETCH_EN   = (c >= 6);
      JMP_VLD    = (c == 10);
      JMP_ADDR   = 24'h000100;
      INST_READY = (c >= 11);
      tick();
      if (c == 10) chk("jmp_pre_vld", 64'(INST_VLD), 64'd1);
      if (c == 11) begin
        chk("jmp_t1_vld", 64'(INST_VLD), 64'd0);
        chk("jmp_t1_cs", 64'(IROM_CS), 64'd1);
      end
      if (c == 12) chk("jmp_t2_vld", 64'(INST_VLD), 64'd0);
      if (c == 13) begin
        chk("jmp_t3_vld", 64'(INST_VLD), 64'd1);
        chk("jmp_t3_pc", 64'(INST_PC), 64'h100);
      end
      nxt();
    end
    JMP_VLD = 1'b0;

    // pc wraps modulo 2^24.
    want[0] = 24'hFFFFFE;
    want[1] = 24'hFFFFFF;
    want[2] = 24'h000000;
    want[3] = 24'h000001;
    for (int i = 0; i < 4; i++) got[i] = 'x;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      JMP_VLD  = (c == 0);
      JMP_ADDR = 24'hFFFFFE;
      tick();
      if (!JMP_VLD && INST_VLD && INST_READY && n < 4) begin
        got[n] = INST_PC;
        n++;
      end
      nxt();
    end
    JMP_VLD = 1'b0;
    for (int i = 0; i < 4; i++) chk("wrap_pc", 64'(got[i]), 64'(want[i]));

    // Drop FETCH_EN: in-flight word drains, no new reads, then sequential resume.
    ncs = 0;
    for (int c = 0; c < 20; c++) begin
      FETCH_EN = (c >= 8);
      tick();
      if (c >= 1 && c <= 7) ncs += int'(IROM_CS);
      if (c == 7) begin
        chk("fen_cs_none", 64'(ncs), 64'd0);
        chk("fen_drained", 64'(sb.size()), 64'd0);
        chk("fen_vld", 64'(INST_VLD), 64'd0);
      end
      if (c == 9) chk("fen_resume_cs", 64'(IROM_CS), 64'd1);
      nxt();
    end

    // Asynchronous reset in the middle of a stream.
    for (int c = 0; c < 5; c++) begin
      tick();
      nxt();
    end
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("arst");
    nxt();
    sb.delete();
    exp_pc = RESET_PC;
    RST_N  = 1'b1;
    seen     = 1'b0;
    first_pc = 'x;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!seen && INST_VLD && INST_READY) begin
        first_pc = INST_PC;
        seen     = 1'b1;
      end
      nxt();
    end
    chk("arst_first_pc", 64'(first_pc), 64'(RESET_PC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
